// File: rtl/id_ex_if.sv
// Signal bundle between decode, the forwarding sources and the ID/EX stage.
// The master drives the ID-side and forwarding inputs; the slave is the stage itself.
interface id_ex_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
);
  logic              in_hold;
  logic              in_flush;
  logic              in_valid;
  logic [OP_W-1:0]   in_ALUOperation_4;
  logic [DATA_W-1:0] in_rs_data_32;
  logic [DATA_W-1:0] in_rt_data_32;
  logic [DATA_W-1:0] in_imm_32;
  logic [4:0]        in_shamt_5;
  logic [REG_AW-1:0] in_rs_5;
  logic [REG_AW-1:0] in_rt_5;
  logic [REG_AW-1:0] in_rd_5;
  logic              in_ALUSrc;
  logic              in_RegDst;
  logic              in_RegWrite;
  logic              in_MemRead;
  logic              in_MemWrite;
  logic              in_MemtoReg;
  logic              in_exmem_RegWrite;
  logic [REG_AW-1:0] in_exmem_wreg_5;
  logic [DATA_W-1:0] in_exmem_result_32;
  logic              in_memwb_RegWrite;
  logic [REG_AW-1:0] in_memwb_wreg_5;
  logic [DATA_W-1:0] in_memwb_result_32;

  logic [DATA_W-1:0] o_A_32;
  logic [DATA_W-1:0] o_B_32;
  logic [DATA_W-1:0] o_store_data_32;
  logic [OP_W-1:0]   o_ALUOperation_4;
  logic [4:0]        o_shamt_5;
  logic [REG_AW-1:0] o_wreg_5;
  logic              o_valid;
  logic              o_RegWrite;
  logic              o_MemRead;
  logic              o_MemWrite;
  logic              o_MemtoReg;
  logic              o_hazard_stall;

  modport master (
    output in_hold, in_flush, in_valid, in_ALUOperation_4, in_rs_data_32, in_rt_data_32,
           in_imm_32, in_shamt_5, in_rs_5, in_rt_5, in_rd_5, in_ALUSrc, in_RegDst,
           in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg,
           in_exmem_RegWrite, in_exmem_wreg_5, in_exmem_result_32,
           in_memwb_RegWrite, in_memwb_wreg_5, in_memwb_result_32,
    input  o_A_32, o_B_32, o_store_data_32, o_ALUOperation_4, o_shamt_5, o_wreg_5,
           o_valid, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_hazard_stall
  );

  modport slave (
    input  in_hold, in_flush, in_valid, in_ALUOperation_4, in_rs_data_32, in_rt_data_32,
           in_imm_32, in_shamt_5, in_rs_5, in_rt_5, in_rd_5, in_ALUSrc, in_RegDst,
           in_RegWrite, in_MemRead, in_MemWrite, in_MemtoReg,
           in_exmem_RegWrite, in_exmem_wreg_5, in_exmem_result_32,
           in_memwb_RegWrite, in_memwb_wreg_5, in_memwb_result_32,
    output o_A_32, o_B_32, o_store_data_32, o_ALUOperation_4, o_shamt_5, o_wreg_5,
           o_valid, o_RegWrite, o_MemRead, o_MemWrite, o_MemtoReg, o_hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALUSrc mux and load-use stall detection.
// Optional FORWARDING_EN: without it, operands come straight from the register and any RAW hazard stalls.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input logic   clk,
  input logic   reset,
  id_ex_if.slave bus
);

  logic              ex_valid;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_mem_to_reg;
  logic              ex_alu_src;
  logic [OP_W-1:0]   ex_alu_op;
  logic [4:0]        ex_shamt;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_wreg;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;

  logic              load_use;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  assign load_use = ex_mem_read && ex_valid && (ex_wreg != '0) && bus.in_valid &&
                    ((ex_wreg == bus.in_rs_5) || ((ex_wreg == bus.in_rt_5) && !bus.in_ALUSrc));

`ifdef FORWARDING_EN
  assign hazard = load_use;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    fwd_rs = ex_rs_data;
    fwd_rt = ex_rt_data;
    if (bus.in_exmem_RegWrite && (bus.in_exmem_wreg_5 != '0) && (bus.in_exmem_wreg_5 == ex_rs))
      fwd_rs = bus.in_exmem_result_32;
    else if (bus.in_memwb_RegWrite && (bus.in_memwb_wreg_5 != '0) && (bus.in_memwb_wreg_5 == ex_rs))
      fwd_rs = bus.in_memwb_result_32;
    if (bus.in_exmem_RegWrite && (bus.in_exmem_wreg_5 != '0) && (bus.in_exmem_wreg_5 == ex_rt))
      fwd_rt = bus.in_exmem_result_32;
    else if (bus.in_memwb_RegWrite && (bus.in_memwb_wreg_5 != '0) && (bus.in_memwb_wreg_5 == ex_rt))
      fwd_rt = bus.in_memwb_result_32;
  end
`else
  logic raw_ex;
  logic raw_mem;

  // Without bypass paths, wait until the producer has left MEM and the register file has the value.
  assign raw_ex  = ex_valid && ex_reg_write && (ex_wreg != '0) &&
                   ((ex_wreg == bus.in_rs_5) || (ex_wreg == bus.in_rt_5));
  assign raw_mem = bus.in_exmem_RegWrite && (bus.in_exmem_wreg_5 != '0) &&
                   ((bus.in_exmem_wreg_5 == bus.in_rs_5) || (bus.in_exmem_wreg_5 == bus.in_rt_5));
  assign hazard  = load_use || (bus.in_valid && (raw_ex || raw_mem));
  assign fwd_rs  = ex_rs_data;
  assign fwd_rt  = ex_rt_data;
`endif

  // NOTE: data registers are reset too, so the combinational operand buses read 0 during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_shamt      <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_wreg       <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
    end else if (!bus.in_hold) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (bus.in_flush || hazard) begin
        ex_valid      <= 1'b0;
        ex_reg_write  <= 1'b0;
        ex_mem_read   <= 1'b0;
        ex_mem_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
      end else begin
        ex_valid      <= bus.in_valid;
        ex_reg_write  <= bus.in_RegWrite  && bus.in_valid;
        ex_mem_read   <= bus.in_MemRead   && bus.in_valid;
        ex_mem_write  <= bus.in_MemWrite  && bus.in_valid;
        ex_mem_to_reg <= bus.in_MemtoReg  && bus.in_valid;
        ex_alu_src    <= bus.in_ALUSrc;
        ex_alu_op     <= bus.in_ALUOperation_4;
        ex_shamt      <= bus.in_shamt_5;
        ex_rs         <= bus.in_rs_5;
        ex_rt         <= bus.in_rt_5;
        ex_wreg       <= bus.in_RegDst ? bus.in_rd_5 : bus.in_rt_5;
        ex_rs_data    <= bus.in_rs_data_32;
        ex_rt_data    <= bus.in_rt_data_32;
        ex_imm        <= bus.in_imm_32;
      end
    end
  end

  assign bus.o_A_32           = fwd_rs;
  assign bus.o_store_data_32  = fwd_rt;
  assign bus.o_B_32           = ex_alu_src ? ex_imm : fwd_rt;
  assign bus.o_ALUOperation_4 = ex_alu_op;
  assign bus.o_shamt_5        = ex_shamt;
  assign bus.o_wreg_5         = ex_wreg;
  assign bus.o_valid          = ex_valid;
  assign bus.o_RegWrite       = ex_reg_write;
  assign bus.o_MemRead        = ex_mem_read;
  assign bus.o_MemWrite       = ex_mem_write;
  assign bus.o_MemtoReg       = ex_mem_to_reg;
  assign bus.o_hazard_stall   = hazard;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model. Expectations follow FORWARDING_EN when it is defined.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  id_ex_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) bus ();
  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OP_W(OP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction currently sitting in EX, as the architecture sees it.
  typedef struct {
    bit        valid, rw, mr, mw, m2r, alusrc;
    bit [3:0]  op;
    bit [4:0]  shamt, rs, rt, wreg;
    bit [31:0] rsd, rtd, imm;
  } ex_t;
  ex_t m;

  function automatic void model_reset();
    m = '{default: 0};
  endfunction

  // Value an instruction in EX sees for a source register.
  function automatic bit [31:0] fwd_val(bit [4:0] idx, bit [31:0] regval);
    if (!FWD || idx == 0) return regval;
    if (bus.in_exmem_RegWrite && bus.in_exmem_wreg_5 == idx) return bus.in_exmem_result_32;
    if (bus.in_memwb_RegWrite && bus.in_memwb_wreg_5 == idx) return bus.in_memwb_result_32;
    return regval;
  endfunction

  function automatic bit exp_stall();
    bit [4:0] prod[$];
    bit       stall;
    bit [4:0] rs;
    bit [4:0] rt;
    stall = 0;
    rs = bus.in_rs_5;
    rt = bus.in_rt_5;
    if (!bus.in_valid) return 0;
    if (m.valid && m.mr && m.wreg != 0 && (m.wreg == rs || (m.wreg == rt && !bus.in_ALUSrc)))
      stall = 1;
    if (!FWD) begin
      if (m.valid && m.rw) prod.push_back(m.wreg);
      if (bus.in_exmem_RegWrite) prod.push_back(bus.in_exmem_wreg_5);
      foreach (prod[i])
        if (prod[i] != 0 && (prod[i] == rs || prod[i] == rt)) stall = 1;
    end
    return stall;
  endfunction

  // One clock edge: update the model exactly as the stage should, then settle 1 ns past the edge.
  task automatic step();
    bit stall;
    stall = exp_stall();
    @(posedge clk);
    if (!bus.in_hold) begin
      if (bus.in_flush || stall) begin
        m.valid = 0; m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0;
      end else begin
        m.valid  = bus.in_valid;
        m.rw     = bus.in_RegWrite && bus.in_valid;
        m.mr     = bus.in_MemRead && bus.in_valid;
        m.mw     = bus.in_MemWrite && bus.in_valid;
        m.m2r    = bus.in_MemtoReg && bus.in_valid;
        m.alusrc = bus.in_ALUSrc;
        m.op     = bus.in_ALUOperation_4;
        m.shamt  = bus.in_shamt_5;
        m.rs     = bus.in_rs_5;
        m.rt     = bus.in_rt_5;
        m.wreg   = bus.in_RegDst ? bus.in_rd_5 : bus.in_rt_5;
        m.rsd    = bus.in_rs_data_32;
        m.rtd    = bus.in_rt_data_32;
        m.imm    = bus.in_imm_32;
      end
    end
    #1;
  endtask

  task automatic clear_fwd();
    bus.in_exmem_RegWrite = 0; bus.in_exmem_wreg_5 = 0; bus.in_exmem_result_32 = 0;
    bus.in_memwb_RegWrite = 0; bus.in_memwb_wreg_5 = 0; bus.in_memwb_result_32 = 0;
  endtask

  task automatic set_id(input bit valid, input bit [3:0] op, input bit [4:0] rs, input bit [4:0] rt,
                        input bit [4:0] rd, input bit [31:0] rsd, input bit [31:0] rtd,
                        input bit [31:0] imm, input bit alusrc, input bit regdst,
                        input bit rw, input bit mr, input bit mw, input bit m2r);
    bus.in_valid = valid; bus.in_ALUOperation_4 = op; bus.in_shamt_5 = rd ^ rs;
    bus.in_rs_5 = rs; bus.in_rt_5 = rt; bus.in_rd_5 = rd;
    bus.in_rs_data_32 = rsd; bus.in_rt_data_32 = rtd; bus.in_imm_32 = imm;
    bus.in_ALUSrc = alusrc; bus.in_RegDst = regdst;
    bus.in_RegWrite = rw; bus.in_MemRead = mr; bus.in_MemWrite = mw; bus.in_MemtoReg = m2r;
  endtask

  task automatic clear_inputs();
    bus.in_hold = 0; bus.in_flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
  endtask

  task automatic test_reset();
    clear_inputs();
    set_id(1, 4'h6, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 0, 1, 1, 1, 1, 1);
    step();
    n_checks++;
    if (bus.o_valid !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_valid: got %b expected 1", bus.o_valid);
    end
    bus.in_exmem_RegWrite = 1; bus.in_exmem_wreg_5 = 0; bus.in_exmem_result_32 = 32'hDEAD_BEEF;
    #2 reset = 1;
    #1;
    model_reset();
    n_checks++;
    if ({bus.o_valid, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg, bus.o_hazard_stall} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.o_valid, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg, bus.o_hazard_stall});
    end
    n_checks++;
    if ({bus.o_wreg_5, bus.o_ALUOperation_4, bus.o_shamt_5} !== 14'b0) begin
      n_fail++; $display("FAIL reset_fields: wreg %h op %h shamt %h expected 0", bus.o_wreg_5, bus.o_ALUOperation_4, bus.o_shamt_5);
    end
    n_checks++;
    if ({bus.o_A_32, bus.o_B_32, bus.o_store_data_32} !== 96'b0) begin
      n_fail++; $display("FAIL reset_operands: A %h B %h st %h expected 0", bus.o_A_32, bus.o_B_32, bus.o_store_data_32);
    end
    #1 reset = 0;
    clear_inputs();
  endtask

  task automatic test_forwarding();
    bit [31:0] exp;
    clear_inputs();
    // add r9 <- r3 + r4
    set_id(1, 4'h2, 5'd3, 5'd4, 5'd9, 32'd5, 32'd7, 32'h0, 0, 1, 1, 0, 0, 0);
    step();
    bus.in_valid = 0;
    bus.in_exmem_RegWrite = 1; bus.in_exmem_wreg_5 = 3; bus.in_exmem_result_32 = 32'h10;
    bus.in_memwb_RegWrite = 1; bus.in_memwb_wreg_5 = 4; bus.in_memwb_result_32 = 32'h20;
    #1;
    exp = FWD ? 32'h10 : 32'd5;
    n_checks++;
    if (bus.o_A_32 !== exp) begin n_fail++; $display("FAIL fwd_A_exmem: got %h expected %h", bus.o_A_32, exp); end
    exp = FWD ? 32'h20 : 32'd7;
    n_checks++;
    if (bus.o_B_32 !== exp) begin n_fail++; $display("FAIL fwd_B_memwb: got %h expected %h", bus.o_B_32, exp); end
    n_checks++;
    if (bus.o_store_data_32 !== exp) begin n_fail++; $display("FAIL fwd_store: got %h expected %h", bus.o_store_data_32, exp); end
    // both producers target rs: EX/MEM is younger and wins
    bus.in_memwb_wreg_5 = 3; bus.in_exmem_result_32 = 32'hAA; bus.in_memwb_result_32 = 32'hBB;
    #1;
    exp = FWD ? 32'hAA : 32'd5;
    n_checks++;
    if (bus.o_A_32 !== exp) begin n_fail++; $display("FAIL fwd_priority: got %h expected %h", bus.o_A_32, exp); end
    clear_fwd();
    set_id(1, 4'h2, 5'd0, 5'd4, 5'd9, 32'h55, 32'd7, 32'h0, 0, 1, 1, 0, 0, 0);
    step();
    bus.in_valid = 0;
    bus.in_exmem_RegWrite = 1; bus.in_exmem_wreg_5 = 0; bus.in_exmem_result_32 = 32'hAA;
    bus.in_memwb_RegWrite = 1; bus.in_memwb_wreg_5 = 0; bus.in_memwb_result_32 = 32'hBB;
    #1;
    n_checks++;
    if (bus.o_A_32 !== 32'h55) begin n_fail++; $display("FAIL fwd_reg0: got %h expected 00000055", bus.o_A_32); end
    clear_fwd();
  endtask

  task automatic test_load_use();
    bit exp;
    clear_inputs();
    // lw r8, imm(r1)
    set_id(1, 4'h2, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1, 0, 1);
    step();
    set_id(1, 4'h2, 5'd8, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    #1;
    n_checks++;
    if (bus.o_hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_rs: got %b expected 1", bus.o_hazard_stall); end
    step();
    n_checks++;
    if ({bus.o_valid, bus.o_RegWrite, bus.o_MemRead} !== 3'b000) begin
      n_fail++; $display("FAIL lu_bubble: got %b expected 000", {bus.o_valid, bus.o_RegWrite, bus.o_MemRead});
    end
    n_checks++;
    if (bus.o_hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop: got %b expected 0", bus.o_hazard_stall); end
    step();
    n_checks++;
    if ({bus.o_valid, bus.o_wreg_5} !== {1'b1, 5'd10}) begin
      n_fail++; $display("FAIL lu_resume: valid %b wreg %0d expected 1/10", bus.o_valid, bus.o_wreg_5);
    end
    // lw r8 then a consumer using r8 only as rt with ALUSrc=1
    set_id(1, 4'h2, 5'd1, 5'd8, 5'd0, 32'h100, 32'h0, 32'h4, 1, 0, 1, 1, 0, 1);
    step();
    set_id(1, 4'h2, 5'd2, 5'd8, 5'd0, 32'h1, 32'h2, 32'h8, 1, 0, 1, 0, 0, 0);
    #1;
    exp = FWD ? 1'b0 : 1'b1;
    n_checks++;
    if (bus.o_hazard_stall !== exp) begin n_fail++; $display("FAIL lu_rt_imm: got %b expected %b", bus.o_hazard_stall, exp); end
    // hold plus hazard: hold wins and the request stays up
    set_id(1, 4'h2, 5'd8, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 0, 1, 1, 0, 0, 0);
    bus.in_hold = 1;
    step();
    step();
    n_checks++;
    if ({bus.o_hazard_stall, bus.o_MemRead, bus.o_valid} !== 3'b111) begin
      n_fail++; $display("FAIL hold_hazard: got %b expected 111", {bus.o_hazard_stall, bus.o_MemRead, bus.o_valid});
    end
    // reset in the middle of a stall clears the request at once
    #2 reset = 1;
    #1;
    model_reset();
    n_checks++;
    if (bus.o_hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall: got %b expected 0", bus.o_hazard_stall); end
    #1 reset = 0;
    clear_inputs();
  endtask

  task automatic test_flush();
    bit [4:0] prev_wreg;
    clear_inputs();
    set_id(1, 4'h1, 5'd1, 5'd2, 5'd12, 32'h1, 32'h2, 32'h3, 0, 1, 1, 0, 0, 0);
    step();
    prev_wreg = 5'd12;
    set_id(1, 4'h7, 5'd3, 5'd4, 5'd13, 32'h9, 32'h9, 32'h9, 0, 1, 1, 0, 1, 0);
    bus.in_flush = 1;
    step();
    bus.in_flush = 0;
    n_checks++;
    if ({bus.o_valid, bus.o_MemWrite, bus.o_RegWrite} !== 3'b000) begin
      n_fail++; $display("FAIL flush_ctrl: got %b expected 000", {bus.o_valid, bus.o_MemWrite, bus.o_RegWrite});
    end
    n_checks++;
    if (bus.o_wreg_5 !== prev_wreg) begin n_fail++; $display("FAIL flush_held_wreg: got %0d expected %0d", bus.o_wreg_5, prev_wreg); end
  endtask

  task automatic test_hold();
    clear_inputs();
    set_id(1, 4'h3, 5'd5, 5'd6, 5'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 0, 1, 1, 0, 0, 0);
    step();
    bus.in_hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             1'($urandom), 1'($urandom), 1, 0, 1'($urandom), 0);
      step();
      n_checks++;
      if ({bus.o_valid, bus.o_ALUOperation_4, bus.o_wreg_5, bus.o_A_32} !== {1'b1, 4'h3, 5'd7, 32'h1234_5678}) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: valid %b op %h wreg %0d A %h expected 1/3/7/12345678",
                 i, bus.o_valid, bus.o_ALUOperation_4, bus.o_wreg_5, bus.o_A_32);
      end
    end
    bus.in_hold = 0;
    set_id(1, 4'h5, 5'd1, 5'd2, 5'd11, 32'hCAFE_0001, 32'hCAFE_0002, 32'h0, 0, 1, 1, 0, 0, 0);
    step();
    n_checks++;
    if ({bus.o_ALUOperation_4, bus.o_wreg_5, bus.o_A_32, bus.o_B_32} !== {4'h5, 5'd11, 32'hCAFE_0001, 32'hCAFE_0002}) begin
      n_fail++;
      $display("FAIL hold_release: op %h wreg %0d A %h B %h expected 5/11/cafe0001/cafe0002",
               bus.o_ALUOperation_4, bus.o_wreg_5, bus.o_A_32, bus.o_B_32);
    end
  endtask

  task automatic test_random();
    bit [31:0] exp_a, exp_st, exp_b;
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      bus.in_hold  = ($urandom_range(0, 7) == 0);
      bus.in_flush = ($urandom_range(0, 7) == 0);
      set_id($urandom_range(0, 3) != 0, 4'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.in_shamt_5 = 5'($urandom);
      bus.in_exmem_RegWrite = 1'($urandom); bus.in_exmem_wreg_5 = 5'($urandom_range(0, 3));
      bus.in_exmem_result_32 = $urandom;
      bus.in_memwb_RegWrite = 1'($urandom); bus.in_memwb_wreg_5 = 5'($urandom_range(0, 3));
      bus.in_memwb_result_32 = $urandom;
      #1;
      exp_a  = fwd_val(m.rs, m.rsd);
      exp_st = fwd_val(m.rt, m.rtd);
      exp_b  = m.alusrc ? m.imm : exp_st;
      n_checks++;
      if (bus.o_hazard_stall !== exp_stall()) begin
        n_fail++; $display("FAIL rand%0d_stall: got %b expected %b", i, bus.o_hazard_stall, exp_stall());
      end
      n_checks++;
      if ({bus.o_A_32, bus.o_B_32, bus.o_store_data_32} !== {exp_a, exp_b, exp_st}) begin
        n_fail++; $display("FAIL rand%0d_operands: A %h B %h st %h expected %h %h %h",
                           i, bus.o_A_32, bus.o_B_32, bus.o_store_data_32, exp_a, exp_b, exp_st);
      end
      n_checks++;
      if ({bus.o_valid, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg,
           bus.o_ALUOperation_4, bus.o_shamt_5, bus.o_wreg_5} !==
          {m.valid, m.rw, m.mr, m.mw, m.m2r, m.op, m.shamt, m.wreg}) begin
        n_fail++; $display("FAIL rand%0d_ctrl: ctl %b op %h sh %0d wreg %0d expected %b %h %0d %0d", i,
                           {bus.o_valid, bus.o_RegWrite, bus.o_MemRead, bus.o_MemWrite, bus.o_MemtoReg},
                           bus.o_ALUOperation_4, bus.o_shamt_5, bus.o_wreg_5,
                           {m.valid, m.rw, m.mr, m.mw, m.m2r}, m.op, m.shamt, m.wreg);
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
